// File: rtl/br_pkg.sv
// Shared definitions for the branch controller: op encodings, FSM states,
// flush counter width and the branch decision helper.
package br_pkg;

  localparam int FLUSH_CNT_W = 3;

  typedef enum logic [1:0] {
    OP_BEQ = 2'b00,
    OP_BGT = 2'b01,
    OP_BLT = 2'b10,
    OP_JMP = 2'b11
  } br_op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_CMP     = 2'b01,
    S_RESOLVE = 2'b10,
    S_FLUSH   = 2'b11
  } br_state_e;

  function automatic logic branch_taken(br_op_e op, logic eq, logic gt, logic lt);
    unique case (op)
      OP_BEQ:  branch_taken = eq;
      OP_BGT:  branch_taken = gt;
      OP_BLT:  branch_taken = lt;
      default: branch_taken = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Branch request/resolution bus between decode (master) and the branch
// controller (slave).
interface branch_ctrl_if
  import br_pkg::*;
#(
  parameter int DW = 16
);
  logic          br_valid;
  logic          br_ready;
  br_op_e        br_op;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] pc;
  logic [DW-1:0] offset;
  logic          kill;
  logic          br_done;
  logic          br_taken;
  logic [DW-1:0] br_target;
  logic          stall;
  logic          flush;

  modport master (
    output br_valid, br_op, op_a, op_b, pc, offset, kill,
    input  br_ready, br_done, br_taken, br_target, stall, flush
  );

  modport slave (
    input  br_valid, br_op, op_a, op_b, pc, offset, kill,
    output br_ready, br_done, br_taken, br_target, stall, flush
  );
endinterface

// File: rtl/br_cmp.sv
// Registered unsigned magnitude comparator; results appear one cycle after
// the operands.
module br_cmp #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          eq,
  output logic          gt,
  output logic          lt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq <= 1'b0;
      gt <= 1'b0;
      lt <= 1'b0;
    end else begin
      eq <= (a == b);
      gt <= (a > b);
      lt <= (a < b);
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: IDLE -> CMP -> RESOLVE [-> FLUSH] -> IDLE.
// Define BRANCH_CTRL_STATS_EN to add saturating taken/not-taken counters.
module branch_ctrl
  import br_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int DW           = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  branch_ctrl_if.slave bus
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [15:0]  taken_cnt,
  output logic [15:0]  nottaken_cnt
`endif
);

  localparam bit HAS_FLUSH = (FLUSH_CYCLES > 0);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD =
    HAS_FLUSH ? FLUSH_CNT_W'(FLUSH_CYCLES - 1) : '0;

  br_state_e              state, state_nxt;
  logic [FLUSH_CNT_W-1:0] cnt, cnt_nxt;
  br_op_e                 op_r;
  logic [DW-1:0]          a_r, b_r, pc_r, off_r;
  logic                   eq, gt, lt;
  logic                   accept, taken_now, taken_q;
  logic [DW-1:0]          target_now, target_q;

  assign accept = bus.br_valid & bus.br_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r  <= OP_BEQ;
      a_r   <= '0;
      b_r   <= '0;
      pc_r  <= '0;
      off_r <= '0;
    end else if (accept) begin
      op_r  <= bus.br_op;
      a_r   <= bus.op_a;
      b_r   <= bus.op_b;
      pc_r  <= bus.pc;
      off_r <= bus.offset;
    end
  end

  br_cmp #(.DW(DW)) u_cmp (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a_r),
    .b     (b_r),
    .eq    (eq),
    .gt    (gt),
    .lt    (lt)
  );

  // pc/offset stay stable from accept through RESOLVE, so the adder needs no stage
  assign taken_now  = branch_taken(op_r, eq, gt, lt);
  assign target_now = pc_r + off_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (bus.kill) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        S_IDLE:    if (accept) state_nxt = S_CMP;
        S_CMP:     state_nxt = S_RESOLVE;
        S_RESOLVE: begin
          if (taken_now && HAS_FLUSH) begin
            state_nxt = S_FLUSH;
            cnt_nxt   = FLUSH_LOAD;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_FLUSH: begin
          if (cnt == '0) state_nxt = S_IDLE;
          else           cnt_nxt   = cnt - 1'b1;
        end
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Result holders keep taken/target stable between resolutions, even across kills
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_q  <= 1'b0;
      target_q <= '0;
    end else if (state == S_RESOLVE) begin
      taken_q  <= taken_now;
      target_q <= target_now;
    end
  end

  assign bus.br_ready  = rst_n & (state == S_IDLE) & ~bus.kill;
  assign bus.br_done   = (state == S_RESOLVE);
  assign bus.br_taken  = (state == S_RESOLVE) ? taken_now  : taken_q;
  assign bus.br_target = (state == S_RESOLVE) ? target_now : target_q;
  assign bus.stall     = (state != S_IDLE);
  assign bus.flush     = ((state == S_RESOLVE) & taken_now) | (state == S_FLUSH);

`ifdef BRANCH_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt    <= '0;
      nottaken_cnt <= '0;
    end else if (state == S_RESOLVE) begin
      if (taken_now) begin
        if (taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
      end else begin
        if (nottaken_cnt != 16'hFFFF) nottaken_cnt <= nottaken_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
